// File: rtl/gon_bus.sv
// gon_bus: gather bus. Round-robin collects packets from SLV_NUM slave slots,
// tags each with the slot's configured ID and emits them on one registered
// valid/ready output stream.

// Per-slot ID tag register, loaded by TOP CTRL.
module gon_bus_slot #(
  parameter int ID_BITWIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic [ID_BITWIDTH-1:0] i_id,
  output logic [ID_BITWIDTH-1:0] o_id
);
  // Tag loads on configuration strobe; cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      o_id <= '0;
    else if (i_load) o_id <= i_id;
  end
endmodule

module gon_bus #(
  parameter int ID_BITWIDTH         = 4,
  parameter int PACKET_IN_BITWIDTH  = 8,
  parameter int PACKET_OUT_BITWIDTH = 12,
  parameter int SLV_NUM             = 6
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [SLV_NUM*PACKET_IN_BITWIDTH-1:0] i_data,
  input  logic [SLV_NUM-1:0]                    i_valid,
  output logic [SLV_NUM-1:0]                    o_ready,
  output logic [PACKET_OUT_BITWIDTH-1:0]        o_data,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  input  logic [SLV_NUM*ID_BITWIDTH-1:0]        i_id,
  input  logic                                  i_id_valid
);
  localparam int PW = $clog2(SLV_NUM);

  logic [SLV_NUM-1:0][PACKET_IN_BITWIDTH-1:0] data_arr;
  logic [SLV_NUM-1:0][ID_BITWIDTH-1:0]        id_in, id_q;
  logic [PW-1:0] rr_ptr, grant, ptr_nxt;
  logic          load;

  assign data_arr = i_data;
  assign id_in    = i_id;

  // One ID register per slot; all load together, no partial update.
  for (genvar k = 0; k < SLV_NUM; k++) begin : g_slot
    gon_bus_slot #(.ID_BITWIDTH(ID_BITWIDTH)) u_slot (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (i_id_valid),
      .i_id   (id_in[k]),
      .o_id   (id_q[k])
    );
  end

  // Output register free (empty or draining) and someone is requesting.
  assign load = (~o_valid | i_ready) & (|i_valid);

  // Round-robin search: first valid slot at or after the pointer, wrapping.
  always_comb begin : p_grant
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < SLV_NUM; i++) begin
      idx = (int'(rr_ptr) + i) % SLV_NUM;
      if (!found && i_valid[idx]) begin
        grant = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign ptr_nxt = (grant == PW'(SLV_NUM-1)) ? '0 : grant + 1'b1;

  // Accept strobe is one-hot on the grant; forced low while reset is held.
  assign o_ready = (i_rst && load) ? (SLV_NUM'(1) << grant) : '0;

  // Output stage: capture tagged packet on load, drop valid when drained,
  // hold everything under backpressure.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= {id_q[grant], data_arr[grant]};
      rr_ptr  <= ptr_nxt;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gon_bus.sv
// Directed bench for gon_bus: vector table for steady-state behaviour plus
// hand sequences around reset.
module tb_gon_bus;
  localparam int IDW = 4, PIN = 8, POUT = 12, N = 6;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N*PIN-1:0] i_data;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    o_ready;
  logic [POUT-1:0] o_data;
  logic            o_valid;
  logic            i_ready;
  logic [N*IDW-1:0] i_id;
  logic            i_id_valid;

  gon_bus #(.ID_BITWIDTH(IDW), .PACKET_IN_BITWIDTH(PIN),
            .PACKET_OUT_BITWIDTH(POUT), .SLV_NUM(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .i_id(i_id), .i_id_valid(i_id_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [N-1:0]     vld;
    logic [N*PIN-1:0] data;
    logic             rdy;
    logic             idv;
    logic [N*IDW-1:0] id;
    logic [N-1:0]     exp_ordy;
    logic             exp_ov;
    logic [POUT-1:0]  exp_od;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0, n_fail = 0;

  localparam logic [N*PIN-1:0] D_STD = 48'h15_14_13_12_11_10;
  localparam logic [N*PIN-1:0] D_T2  = 48'h15_14_13_A5_11_10;
  localparam logic [N*IDW-1:0] ID_A  = 24'h012345;
  localparam logic [N*IDW-1:0] ID_F  = 24'hFFFFFF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [N-1:0] vld, logic [N*PIN-1:0] data, logic rdy,
                               logic idv, logic [N*IDW-1:0] id, logic [N-1:0] eor,
                               logic eov, logic [POUT-1:0] eod);
    vec_t v;
    v.vld = vld; v.data = data; v.rdy = rdy; v.idv = idv; v.id = id;
    v.exp_ordy = eor; v.exp_ov = eov; v.exp_od = eod;
    return v;
  endfunction

  initial begin
    // config, then single accept from slot 2 (ID 3)
    tbl.push_back(mkv(6'b000000, D_STD, 1, 1, ID_A, 6'b000000, 0, 12'h000));
    tbl.push_back(mkv(6'b000100, D_T2,  1, 0, ID_A, 6'b000100, 1, 12'h3A5));
    // slot 5 alone: pointer wraps 5 -> 0
    tbl.push_back(mkv(6'b100000, D_STD, 1, 0, ID_A, 6'b100000, 1, 12'h015));
    // all valid: full-rate rotation 0..5,0
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b000001, 1, 12'h510));
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b000010, 1, 12'h411));
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b000100, 1, 12'h312));
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b001000, 1, 12'h213));
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b010000, 1, 12'h114));
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b100000, 1, 12'h015));
    tbl.push_back(mkv(6'b111111, D_STD, 1, 0, ID_A, 6'b000001, 1, 12'h510));
    // backpressure: slots 1 and 4 waiting, output must hold
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(6'b010010, D_STD, 0, 0, ID_A, 6'b000000, 1, 12'h510));
    tbl.push_back(mkv(6'b010010, D_STD, 1, 0, ID_A, 6'b000010, 1, 12'h411));
    tbl.push_back(mkv(6'b010000, D_STD, 1, 0, ID_A, 6'b010000, 1, 12'h114));
    // ID reload on same edge as slot 0 accept: old tag used
    tbl.push_back(mkv(6'b000001, D_STD, 1, 1, ID_F, 6'b000001, 1, 12'h510));
    tbl.push_back(mkv(6'b000000, D_STD, 1, 0, ID_F, 6'b000000, 0, 12'h510));
    tbl.push_back(mkv(6'b000001, D_STD, 1, 0, ID_F, 6'b000001, 1, 12'hF10));
    tbl.push_back(mkv(6'b000000, D_STD, 0, 0, ID_F, 6'b000000, 1, 12'hF10));
    tbl.push_back(mkv(6'b000001, D_STD, 0, 0, ID_F, 6'b000000, 1, 12'hF10));

    // Reset with all inputs high
    i_rst = 1'b0; i_valid = '1; i_data = D_STD; i_ready = 1'b1;
    i_id = ID_F; i_id_valid = 1'b1;
    #3;
    chk("rst_ov", 64'(o_valid), 64'd0);
    chk("rst_ordy", 64'(o_ready), 64'd0);
    chk("rst_od", 64'(o_data), 64'd0);
    @(posedge i_clk); #1;
    chk("rst_ordy_edge", 64'(o_ready), 64'd0);
    chk("rst_ov_edge", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b1; i_valid = '0; i_id_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("idle_ov", 64'(o_valid), 64'd0);
    chk("idle_od", 64'(o_data), 64'd0);
    chk("idle_ordy", 64'(o_ready), 64'd0);

    // Table vectors: o_ready checked before the edge, registers after it
    foreach (tbl[i]) begin
      @(negedge i_clk);
      i_valid = tbl[i].vld; i_data = tbl[i].data; i_ready = tbl[i].rdy;
      i_id_valid = tbl[i].idv; i_id = tbl[i].id;
      #1;
      chk($sformatf("v%0d_ordy", i), 64'(o_ready), 64'(tbl[i].exp_ordy));
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_ov", i), 64'(o_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("v%0d_od", i), 64'(o_data), 64'(tbl[i].exp_od));
    end

    // Mid-burst reset: pointer at 1, accept slots 1 and 2, then reset
    @(negedge i_clk);
    i_valid = '1; i_data = D_STD; i_ready = 1'b1; i_id_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("burst_od1", 64'(o_data), 64'hF11);
    @(posedge i_clk); #1;
    chk("burst_od2", 64'(o_data), 64'hF12);
    #1 i_rst = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(o_valid), 64'd0);
    chk("mid_rst_od", 64'(o_data), 64'd0);
    chk("mid_rst_ordy", 64'(o_ready), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b1; i_valid = 6'b010100;
    #1;
    chk("post_rst_ordy", 64'(o_ready), 64'b000100);
    @(posedge i_clk); #1;
    chk("post_rst_ov", 64'(o_valid), 64'd1);
    chk("post_rst_od", 64'(o_data), 64'h012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
